// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback types for the nebula core: datapath word, register address
// and the writeback entry held by the arbiter's output stage.
package nebula;
  typedef logic [31:0] x_t;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    x_t        data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: NUM_REQ requester channels in, one regfile write port out.
// master = execution units + regfile side, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  nebula::x_t [NUM_REQ-1:0]       req_data_i;
  logic                           wr_ready_i;
  logic                           wr_en_o;
  logic [ADDR_W-1:0]              wr_addr_o;
  nebula::x_t                     wr_data_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, wr_ready_i,
    input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, wr_ready_i,
    output req_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin grant: first set req bit at or after ptr_i,
// wrapping at N-1 -> 0. Pointer state lives in the caller.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o
);
  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        gnt_o[idx]   = 1'b1;
        gnt_idx_o    = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with a one-entry registered write stage.
// Optional NEBULA_WB_STATS_EN adds a saturating contention counter.
module regfile_wb_arbiter
  import nebula::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 busy_o
`ifdef NEBULA_WB_STATS_EN
  ,
  output logic [31:0]          conflict_cnt_o
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);

  wb_req_t            out_q;
  logic [PTR_W-1:0]   rr_q, g_idx, rr_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic               can_accept, accept, retire, to_x0;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i     (bus.req_valid_i),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (g_idx)
  );

  // A stalled entry blocks new grants; a retiring one frees the slot this cycle.
  assign can_accept      = !out_q.valid || bus.wr_ready_i;
  assign bus.req_ready_o = gnt & {NUM_REQ{can_accept && !rst_i}};
  assign accept          = |(bus.req_valid_i & bus.req_ready_o);
  assign retire          = out_q.valid && bus.wr_ready_i;
  assign to_x0           = (bus.req_addr_i[g_idx] == '0);
  assign rr_nxt          = (g_idx == PTR_W'(NUM_REQ-1)) ? '0 : g_idx + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
      rr_q  <= '0;
    end else begin
      if (accept) rr_q <= rr_nxt;
      // x0 writes are consumed here and never reach the port
      if (accept && !to_x0) begin
        out_q.valid <= 1'b1;
        out_q.addr  <= reg_addr_t'(bus.req_addr_i[g_idx]);
        out_q.data  <= bus.req_data_i[g_idx];
      end else if (retire) begin
        out_q <= '0;
      end
    end
  end

  assign bus.wr_en_o   = out_q.valid;
  assign bus.wr_addr_o = ADDR_W'(out_q.addr);
  assign bus.wr_data_o = out_q.data;
  assign busy_o        = out_q.valid;

`ifdef NEBULA_WB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      conflict_cnt_o <= '0;
    else if (($countones(bus.req_valid_i) >= 2) && can_accept && (conflict_cnt_o != 32'hFFFF_FFFF))
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
  end
`endif
endmodule
